router_fsm_ctrl: RTL and testbench
==================================

// Module: router_fsm_ctrl
// PURPOSE
//  Sequencing controller for the 1x3 router ingress path. Decodes the 2-bit
//  destination in the header, then drives the state strobes that step
//  router_register through header, payload, fifo-full and parity handling.
//  Also generates the per-destination FIFO write enables and the source-side
//  busy flag. Sits between the source port, router_register and the three
//  output FIFOs / soft-reset sync block.
// PARAMETERS
//  NUM_DEST   3   number of output FIFOs; addr values >= NUM_DEST are invalid
// PORTS
//  clock             in   1  system clock, all logic on posedge
//  reset             in   1  synchronous reset, active-high
//  packet_valid      in   1  source has a valid byte on data_in
//  data_in           in   2  header address bits data_in[1:0], sampled in DECODE
//  fifo_full         in   1  full flag of the currently selected FIFO
//  fifo_empty        in   3  empty flag per FIFO
//  soft_reset        in   3  per-FIFO soft reset (read-side timeout)
//  parity_done       in   1  from router_register
//  low_packet_valid  in   1  from router_register
//  detect_add        out  1  state==DECODE
//  lfd_state         out  1  state==LFD
//  ld_state          out  1  state==LD
//  laf_state         out  1  state==LAF
//  full_state        out  1  state==FULL
//  rst_int_reg       out  1  state==CHECK
//  busy              out  1  source must hold data_in
//  write_enb         out  3  one-hot FIFO write enable, registered
// BEHAVIOUR
//  Reset: state=DECODE, addr_q=0, write_enb=0; so detect_add=1, others 0.
//  State strobes and busy are Moore, combinational from state only.
//  busy=1 in LFD, FULL, LAF, LP, CHECK, WAIT; 0 in DECODE, LD.
//  addr_q <= data_in[1:0] when state==DECODE && packet_valid && addr valid.
//  Transitions (next state on posedge):
//   DECODE: pv && addr valid && fifo_empty[addr] -> LFD
//           pv && addr valid && !fifo_empty[addr] -> WAIT
//           pv && addr invalid (2'b11) -> DECODE, packet dropped
//           !pv -> DECODE
//   WAIT:   fifo_empty[addr_q] -> LFD, else WAIT
//   LFD:    -> LD unconditionally (header written)
//   LD:     fifo_full -> FULL; else !pv -> LP; else LD
//   FULL:   !fifo_full -> LAF, else FULL
//   LAF:    parity_done -> DECODE
//           !parity_done && low_packet_valid -> LP
//           !parity_done && !low_packet_valid -> LD
//   LP:     -> CHECK
//   CHECK:  fifo_full -> FULL, else DECODE
//  Soft reset: soft_reset[addr_q] in any state other than DECODE forces
//   next state DECODE and clears write_enb; has priority over all arcs
//   above. Sync reset has priority over soft reset.
//  Write enable: router_register updates dout on the edge ending a strobe
//   cycle, so wr_pending is registered one cycle late:
//   wr_pending <= LFD | (LD && !fifo_full) | LAF
//   write_enb = wr_pending ? (3'b001 << addr_q) : 3'b000.
//   Covers payload bytes and parity byte (last LD cycle, pv low).
//  fifo_full is honoured only in LD/FULL/CHECK; ignored elsewhere.
//  Never more than one write_enb bit high; never a strobe in two states.
// STRUCTURE
//  router_pkg: state localparams (3-bit binary: DECODE=0, LFD=1, LD=2, LP=3,
//   CHECK=4, FULL=5, LAF=6, WAIT=7), ADDR_INVALID=2'b11, NUM_DEST.
//  Single module, no sub-module: state reg, next-state logic, addr_q,
//   wr_pending. Unused encodings recover to DECODE.
// TESTING
//  1 addr=2'b01, fifo_empty=3'b111, header+3 payload+parity, no full ->
//    DECODE,LFD,LD x3,LD(pv=0),LP,CHECK,DECODE; write_enb=3'b010 for 5 cycles.
//  2 addr=2'b00, fifo_empty[0]=0 for 4 cycles -> WAIT with busy=1, no
//    write_enb; on empty -> LFD next cycle, write_enb=3'b001 one cycle later.
//  3 fifo_full asserted on 2nd payload byte for 3 cycles -> FULL held 3
//    cycles, write_enb=0 throughout, then LAF, LD; byte count in FIFO intact.
//  4 fifo_full during CHECK -> FULL; low_packet_valid=1, parity_done=1
//    in LAF -> DECODE.
//  5 addr=2'b11 with pv=1 -> stays DECODE, busy=0, write_enb=0, addr_q kept.
//  6 soft_reset[2] while in LD to addr 2 -> DECODE next cycle, write_enb=0;
//    reset=1 mid-LAF -> DECODE, all outputs at reset values.

Source files
------------

// File: rtl/router_fsm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// router_fsm_ctrl_pkg
// Shared definitions for the router ingress sequencing controller:
//   NUM_DEST      number of output FIFOs (addresses >= NUM_DEST are invalid)
//   ADDR_INVALID  header address value reserved as "drop this packet"
//   state_t       3-bit binary controller state encoding
//   addr_is_valid / dest_onehot  small address helpers
// ---------------------------------------------------------------------------
package router_fsm_ctrl_pkg;

  localparam int         NUM_DEST     = 3;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    S_DECODE = 3'd0,
    S_LFD    = 3'd1,
    S_LD     = 3'd2,
    S_LP     = 3'd3,
    S_CHECK  = 3'd4,
    S_FULL   = 3'd5,
    S_LAF    = 3'd6,
    S_WAIT   = 3'd7
  } state_t;

  // An address selects a FIFO only if it is below NUM_DEST and is not the
  // reserved drop code.
  function automatic logic addr_is_valid(input logic [1:0] addr);
    return (addr != ADDR_INVALID) && (int'(addr) < NUM_DEST);
  endfunction

  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [1:0] addr);
    logic [NUM_DEST-1:0] w_one;
    w_one = {{(NUM_DEST-1){1'b0}}, 1'b1};
    return w_one << addr;
  endfunction

endpackage

// File: rtl/router_fsm_ctrl_if.sv
// ---------------------------------------------------------------------------
// router_fsm_ctrl_if
// Signal bundle between the source port / router_register / output FIFOs
// (master side) and the sequencing controller (slave side).
//   master drives : packet_valid, data_in, fifo_full, fifo_empty, soft_reset,
//                   parity_done, low_packet_valid
//   slave drives  : detect_add, lfd_state, ld_state, laf_state, full_state,
//                   rst_int_reg, busy, write_enb
// ---------------------------------------------------------------------------
interface router_fsm_ctrl_if
  import router_fsm_ctrl_pkg::*;
  ();

  logic                packet_valid;
  logic [1:0]          data_in;
  logic                fifo_full;
  logic [NUM_DEST-1:0] fifo_empty;
  logic [NUM_DEST-1:0] soft_reset;
  logic                parity_done;
  logic                low_packet_valid;

  logic                detect_add;
  logic                lfd_state;
  logic                ld_state;
  logic                laf_state;
  logic                full_state;
  logic                rst_int_reg;
  logic                busy;
  logic [NUM_DEST-1:0] write_enb;

  modport master (
    output packet_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_packet_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, busy, write_enb
  );

  modport slave (
    input  packet_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_packet_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, busy, write_enb
  );

endinterface

// File: rtl/router_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// router_fsm_ctrl
// Sequencing controller for the 1x3 router ingress path. Decodes the header
// destination, steps router_register through header / payload / fifo-full /
// parity handling via Moore state strobes, raises busy toward the source and
// generates the one-hot FIFO write enable.
// Ports:
//   clock  in  system clock, all logic on posedge
//   reset  in  synchronous reset, active-high (priority over soft reset)
//   bus    router_fsm_ctrl_if.slave - handshake, FIFO status and strobes
// ---------------------------------------------------------------------------
module router_fsm_ctrl
  import router_fsm_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  router_fsm_ctrl_if.slave  bus
);

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_addr_q;
  logic [NUM_DEST-1:0] r_write_enb;

  logic                w_addr_valid;
  logic                w_soft_rst;
  logic                w_wr_req;

  assign w_addr_valid = addr_is_valid(bus.data_in);

  // Soft reset of the FIFO we are currently feeding abandons the packet;
  // in DECODE there is no packet in flight, so it is ignored there.
  assign w_soft_rst = (r_state != S_DECODE) && bus.soft_reset[r_addr_q];

  // router_register presents the byte on the edge that ends a strobe cycle,
  // so the FIFO write is issued one cycle after the strobe.
  assign w_wr_req = (r_state == S_LFD) ||
                    ((r_state == S_LD) && !bus.fifo_full) ||
                    (r_state == S_LAF);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_DECODE: begin
        if (bus.packet_valid && w_addr_valid) begin
          w_state_next = bus.fifo_empty[bus.data_in] ? S_LFD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.fifo_empty[r_addr_q]) w_state_next = S_LFD;
      end
      S_LFD: w_state_next = S_LD;
      S_LD: begin
        if (bus.fifo_full)          w_state_next = S_FULL;
        else if (!bus.packet_valid) w_state_next = S_LP;
      end
      S_FULL: begin
        if (!bus.fifo_full) w_state_next = S_LAF;
      end
      S_LAF: begin
        if (bus.parity_done)           w_state_next = S_DECODE;
        else if (bus.low_packet_valid) w_state_next = S_LP;
        else                           w_state_next = S_LD;
      end
      S_LP:    w_state_next = S_CHECK;
      S_CHECK: w_state_next = bus.fifo_full ? S_FULL : S_DECODE;
      default: w_state_next = S_DECODE;
    endcase
    if (w_soft_rst) w_state_next = S_DECODE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_DECODE;
      r_addr_q    <= 2'b00;
      r_write_enb <= '0;
    end else begin
      r_state <= w_state_next;
      // Invalid headers leave the previous destination untouched.
      if ((r_state == S_DECODE) && bus.packet_valid && w_addr_valid) begin
        r_addr_q <= bus.data_in;
      end
      if (w_soft_rst)    r_write_enb <= '0;
      else if (w_wr_req) r_write_enb <= dest_onehot(r_addr_q);
      else               r_write_enb <= '0;
    end
  end

  assign bus.detect_add  = (r_state == S_DECODE);
  assign bus.lfd_state   = (r_state == S_LFD);
  assign bus.ld_state    = (r_state == S_LD);
  assign bus.laf_state   = (r_state == S_LAF);
  assign bus.full_state  = (r_state == S_FULL);
  assign bus.rst_int_reg = (r_state == S_CHECK);
  assign bus.busy        = (r_state != S_DECODE) && (r_state != S_LD);
  assign bus.write_enb   = r_write_enb;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_router_fsm_ctrl
// Directed packet scenarios followed by random traffic, every cycle compared
// against a behavioural model of the controller that tracks the phase by name.
// ---------------------------------------------------------------------------
module tb_router_fsm_ctrl;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  router_fsm_ctrl_if bus ();

  router_fsm_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int we_cycles = 0;

  // behavioural model
  string      m_state;
  int         m_addr;
  logic [2:0] m_we;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [5:0] exp_strb;
    logic [5:0] obs_strb;
    logic       exp_busy;
    exp_strb = {m_state == "DECODE", m_state == "LFD", m_state == "LD",
                m_state == "LAF", m_state == "FULL", m_state == "CHECK"};
    obs_strb = {bus.detect_add, bus.lfd_state, bus.ld_state,
                bus.laf_state, bus.full_state, bus.rst_int_reg};
    exp_busy = !(m_state == "DECODE" || m_state == "LD");
    check($sformatf("strobes@%s", m_state), 8'(obs_strb), 8'(exp_strb));
    check($sformatf("busy@%s", m_state), 8'(bus.busy), 8'(exp_busy));
    check($sformatf("write_enb@%s", m_state), 8'(bus.write_enb), 8'(m_we));
    if (bus.write_enb !== 3'b000) we_cycles++;
  endtask

  task automatic model_step(input logic pv, input logic [1:0] din, input logic full,
                            input logic [2:0] empty, input logic [2:0] srst,
                            input logic pd, input logic lpv, input logic rst);
    logic       writes;
    logic [2:0] nxt_we;
    if (rst) begin
      m_state = "DECODE"; m_addr = 0; m_we = 3'b000;
      return;
    end
    if (m_state != "DECODE" && srst[m_addr]) begin
      m_state = "DECODE"; m_we = 3'b000;
      return;
    end
    writes = (m_state == "LFD") || (m_state == "LAF") || (m_state == "LD" && !full);
    nxt_we = 3'b000;
    if (writes) nxt_we[m_addr] = 1'b1;
    m_we = nxt_we;
    if (m_state == "DECODE") begin
      if (pv && din != 2'd3) begin
        m_state = empty[din] ? "LFD" : "WAIT";
        m_addr  = int'(din);
      end
    end else if (m_state == "WAIT") begin
      if (empty[m_addr]) m_state = "LFD";
    end else if (m_state == "LFD") begin
      m_state = "LD";
    end else if (m_state == "LD") begin
      if (full) m_state = "FULL";
      else if (!pv) m_state = "LP";
    end else if (m_state == "FULL") begin
      if (!full) m_state = "LAF";
    end else if (m_state == "LAF") begin
      if (pd) m_state = "DECODE";
      else if (lpv) m_state = "LP";
      else m_state = "LD";
    end else if (m_state == "LP") begin
      m_state = "CHECK";
    end else if (m_state == "CHECK") begin
      m_state = full ? "FULL" : "DECODE";
    end
  endtask

  // One clock cycle: check current outputs, apply inputs, advance DUT+model.
  task automatic tick(input logic pv, input logic [1:0] din, input logic full,
                      input logic [2:0] empty, input logic [2:0] srst,
                      input logic pd, input logic lpv, input logic rst);
    check_outputs();
    bus.packet_valid     = pv;
    bus.data_in          = din;
    bus.fifo_full        = full;
    bus.fifo_empty       = empty;
    bus.soft_reset       = srst;
    bus.parity_done      = pd;
    bus.low_packet_valid = lpv;
    reset                = rst;
    @(posedge clock);
    model_step(pv, din, full, empty, srst, pd, lpv, rst);
    @(negedge clock);
  endtask

  initial begin
    int c0;
    int c1;
    reset = 1'b1;
    bus.packet_valid = 1'b0; bus.data_in = 2'b00; bus.fifo_full = 1'b0;
    bus.fifo_empty = 3'b111; bus.soft_reset = 3'b000;
    bus.parity_done = 1'b0; bus.low_packet_valid = 1'b0;
    @(posedge clock);
    model_step(0, 0, 0, 3'b111, 0, 0, 0, 1);
    @(negedge clock);

    // 1: packet to FIFO 1, header + 3 payload + parity
    we_cycles = 0;
    tick(1, 2'b01, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b10, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b11, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b01, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    check("s1_write_cycles", 8'(we_cycles), 8'd5);

    // 2: FIFO 0 not empty -> WAIT, then released
    we_cycles = 0;
    tick(1, 2'b00, 0, 3'b110, 0, 0, 0, 0);
    tick(1, 2'b00, 0, 3'b110, 0, 0, 0, 0);
    tick(1, 2'b00, 0, 3'b110, 0, 0, 0, 0);
    tick(1, 2'b00, 0, 3'b110, 0, 0, 0, 0);
    check("s2_wait_no_write", 8'(we_cycles), 8'd0);
    check("s2_wait_busy", 8'(bus.busy), 8'd1);
    tick(1, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);

    // 3: fifo_full on 2nd payload byte for 3 cycles
    c0 = we_cycles;
    tick(1, 2'b10, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b01, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b01, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b01, 1, 3'b111, 0, 0, 0, 0);
    c1 = we_cycles;
    tick(1, 2'b01, 1, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b01, 1, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b01, 0, 3'b111, 0, 0, 0, 0);
    check("s3_full_no_write", 8'(we_cycles - c1), 8'd0);
    tick(1, 2'b01, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    check("s3_byte_count", 8'(we_cycles - c0), 8'd4);

    // 4: fifo_full during CHECK, parity_done in LAF
    tick(1, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 1, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 1, 1, 0);
    tick(0, 2'b00, 0, 3'b111, 0, 0, 0, 0);

    // 5: invalid address dropped
    tick(1, 2'b11, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b11, 0, 3'b111, 0, 0, 0, 0);
    check("s5_busy", 8'(bus.busy), 8'd0);
    check("s5_detect", 8'(bus.detect_add), 8'd1);
    check("s5_write_enb", 8'(bus.write_enb), 8'd0);

    // 6: soft reset in LD, then sync reset mid-LAF
    tick(1, 2'b10, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b10, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b10, 0, 3'b111, 3'b100, 0, 0, 0);
    check("s6_soft_detect", 8'(bus.detect_add), 8'd1);
    check("s6_soft_we", 8'(bus.write_enb), 8'd0);
    tick(1, 2'b01, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b01, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b01, 1, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b01, 0, 3'b111, 0, 0, 0, 0);
    tick(1, 2'b01, 0, 3'b111, 3'b010, 0, 0, 1);
    check("s6_rst_strobes",
          8'({bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
              bus.full_state, bus.rst_int_reg}), 8'b0010_0000);
    check("s6_rst_busy", 8'(bus.busy), 8'd0);
    check("s6_rst_we", 8'(bus.write_enb), 8'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic       r_pv, r_full, r_pd, r_lpv, r_rst;
      logic [1:0] r_din;
      logic [2:0] r_empty, r_srst;
      r_pv    = ($urandom_range(0, 3) != 0);
      r_din   = 2'($urandom_range(0, 3));
      r_full  = ($urandom_range(0, 4) == 0);
      r_empty = 3'($urandom);
      r_srst  = ($urandom_range(0, 31) == 0) ? 3'($urandom) : 3'b000;
      r_pd    = ($urandom_range(0, 2) == 0);
      r_lpv   = 1'($urandom);
      r_rst   = ($urandom_range(0, 199) == 0);
      tick(r_pv, r_din, r_full, r_empty, r_srst, r_pd, r_lpv, r_rst);
    end
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
